// File: rtl/fft_pkg.sv
// Shared FFT definitions: float word width, per-stage frame constants,
// sequencer state encoding and the complex sample type.
package fft_pkg;

  localparam int FLOAT_W       = 32;
  localparam int STAGE9_ADDR_W = 8;
  localparam int STAGE9_FRAME  = 512;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [FLOAT_W-1:0] re;
    logic [FLOAT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/twiddle_seq_stage_9.sv
// FFT stage-9 twiddle sequencer: counts samples within a 512-point frame,
// addresses the stage twiddle ROM and delays the complex sample by two
// cycles so it meets its angle (ROM read data) at the CORDIC input.
module twiddle_seq_stage_9
  import fft_pkg::*;
#(
  parameter int DATA_W = FLOAT_W,
  parameter int ADDR_W = STAGE9_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_rot_en,
  output logic [DATA_W-1:0] o_re,
  output logic [DATA_W-1:0] o_im,
  output logic [DATA_W-1:0] o_angle,
  output logic              o_sync_err
);

  localparam int N_W = ADDR_W + 1;
  localparam logic [N_W-1:0] N_LAST = '1;

  // First half of the frame always reads ROM[0] (-0.0); second half reads k = n - half.
  function automatic logic [ADDR_W-1:0] f_rom_addr(input logic [N_W-1:0] n);
    return n[N_W-1] ? n[ADDR_W-1:0] : '0;
  endfunction

  seq_state_t        r_state;
  logic [N_W-1:0]    r_n;

  logic              w_accept_p0;
  logic              w_resync_p0;
  logic [N_W-1:0]    w_idx_p0;

  logic              r_vld_p1;
  logic              r_sof_p1;
  logic              r_eof_p1;
  logic              r_rot_p1;
  logic              r_err_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_re_p1;
  logic [DATA_W-1:0] r_im_p1;

  logic              r_vld_p2;
  logic              r_sof_p2;
  logic              r_eof_p2;
  logic              r_rot_p2;
  logic              r_err_p2;
  logic [DATA_W-1:0] r_re_p2;
  logic [DATA_W-1:0] r_im_p2;

  // Input qualification: which sample is accepted and at what frame index
  always_comb begin
    w_accept_p0 = i_valid & ((r_state == S_RUN) | i_sof);
    w_idx_p0    = i_sof ? '0 : r_n;
    w_resync_p0 = (r_state == S_RUN) & i_valid & i_sof & (r_n != '0);
  end

  // Sequencer FSM and frame sample counter; an i_sof always restarts at n = 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_n     <= '0;
    end else if (w_accept_p0) begin
      r_state <= S_RUN;
      r_n     <= w_idx_p0 + 1'b1;
    end
  end

  // ---- stage A (p1): ROM address issued, sample and flags captured ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1  <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_eof_p1  <= 1'b0;
      r_rot_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_re_p1   <= '0;
      r_im_p1   <= '0;
    end else begin
      r_vld_p1 <= w_accept_p0;
      r_sof_p1 <= w_accept_p0 & i_sof;
      r_eof_p1 <= w_accept_p0 & (w_idx_p0 == N_LAST);
      r_rot_p1 <= w_accept_p0 & w_idx_p0[N_W-1];
      r_err_p1 <= w_resync_p0;
      if (w_accept_p0) begin
        r_addr_p1 <= f_rom_addr(w_idx_p0);
        r_re_p1   <= i_re;
        r_im_p1   <= i_im;
      end
    end
  end

  // ---- stage B (p2): aligned with the ROM's registered read data ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p2 <= 1'b0;
      r_sof_p2 <= 1'b0;
      r_eof_p2 <= 1'b0;
      r_rot_p2 <= 1'b0;
      r_err_p2 <= 1'b0;
      r_re_p2  <= '0;
      r_im_p2  <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_sof_p2 <= r_sof_p1;
      r_eof_p2 <= r_eof_p1;
      r_rot_p2 <= r_rot_p1;
      r_err_p2 <= r_err_p1;
      if (r_vld_p1) begin
        r_re_p2 <= r_re_p1;
        r_im_p2 <= r_im_p1;
      end
    end
  end

  assign o_rom_addr = r_addr_p1;
  assign o_valid    = r_vld_p2;
  assign o_sof      = r_sof_p2;
  assign o_eof      = r_eof_p2;
  assign o_rot_en   = r_rot_p2;
  assign o_sync_err = r_err_p2;
  assign o_re       = r_re_p2;
  assign o_im       = r_im_p2;
  assign o_angle    = i_rom_data;

endmodule

// File: tb/tb_twiddle_seq_stage_9.sv
// Bench for twiddle_seq_stage_9: behavioural ROM and frame model plus
// table-driven boundary vectors and directed multi-cycle sequences.
module tb_twiddle_seq_stage_9;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic [31:0] i_re = '0;
  logic [31:0] i_im = '0;
  logic [7:0]  o_rom_addr;
  logic [31:0] rom_q;
  logic        o_valid, o_sof, o_eof, o_rot_en, o_sync_err;
  logic [31:0] o_re, o_im, o_angle;

  twiddle_seq_stage_9 #(.DATA_W(32), .ADDR_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_sof(i_sof),
    .i_re(i_re), .i_im(i_im), .o_rom_addr(o_rom_addr), .i_rom_data(rom_q),
    .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof), .o_rot_en(o_rot_en),
    .o_re(o_re), .o_im(o_im), .o_angle(o_angle), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Round a double to IEEE-754 single (nearest-even), normal range only.
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] k;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e = int'(d[62:52]) - 1023 + 127;
    m = {1'b1, d[51:0]};
    k = {1'b0, m[52:29]};
    if (m[28] && ((|m[27:0]) || m[29])) k = k + 25'd1;
    if (k[24]) begin
      k = k >> 1;
      e = e + 1;
    end
    return {d[63], e[7:0], k[22:0]};
  endfunction

  // rom_stage_9 model: 256 entries of -k*pi/256, one-cycle registered read
  logic [31:0] rom [256];
  initial forever begin
    @(posedge clk);
    rom_q <= rom[o_rom_addr];
  end

  // Frame-level reference model: one expected output record per cycle
  typedef struct {
    bit rst, vld, sof, eof, rot, err;
    logic [31:0] re, im, ang;
  } exp_t;
  exp_t q[$];
  bit   m_run = 1'b0;
  int   m_n = 0;

  initial forever begin
    exp_t e;
    int   idx;
    @(posedge clk);
    cyc++;
    e = '{default: 0};
    if (rst) begin
      q.delete();
      m_run = 1'b0;
      m_n = 0;
      e.rst = 1'b1;
      q.push_back(e);
      q.push_back(e);
    end else begin
      if (i_valid && (m_run || i_sof)) begin
        idx   = i_sof ? 0 : m_n;
        e.vld = 1'b1;
        e.sof = i_sof;
        e.err = m_run && i_sof && (m_n != 0);
        e.eof = (idx == 511);
        e.rot = (idx >= 256);
        e.ang = rom[(idx >= 256) ? idx - 256 : 0];
        e.re  = i_re;
        e.im  = i_im;
        m_run = 1'b1;
        m_n   = (idx + 1) % 512;
      end
      q.push_back(e);
    end
  end

  // Output capture of valid beats plus per-cycle comparison with the model
  typedef struct {
    bit sof, eof, rot, err;
    logic [31:0] ang;
  } cap_t;
  cap_t cap [1200];
  cap_t cref [1200];
  int   cap_n = 0;
  logic [31:0] h_re = '0, h_im = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (o_valid && cap_n < 1200) begin
      cap[cap_n] = '{o_sof, o_eof, o_rot_en, o_sync_err, o_angle};
      cap_n++;
    end
    if (q.size() >= 2) begin
      e = q.pop_front();
      if (e.rst) begin
        h_re = '0;
        h_im = '0;
      end
      if (e.vld) begin
        h_re = e.re;
        h_im = e.im;
      end
      chk("model",
          128'({o_valid, o_sof, o_eof, o_sync_err, o_valid & o_rot_en, o_re, o_im,
                o_valid ? o_angle : 32'h0}),
          128'({e.vld, e.sof, e.eof, e.err, e.rot, h_re, h_im,
                e.vld ? e.ang : 32'h0}));
    end
  end

  task automatic beat(input bit v, input bit s);
    i_valid = v;
    i_sof   = s;
    i_re    = $urandom;
    i_im    = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) beat(1'b0, 1'b0);
  endtask

  task automatic do_reset(input string name);
    rst     = 1'b1;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk(name, 128'({o_valid, o_sof, o_eof, o_rot_en, o_sync_err, o_re, o_im, o_rom_addr}), 128'h0);
  endtask

  typedef struct {
    int beat;
    bit sof, eof, rot, err;
    logic [31:0] ang;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int sent, errs;
    bit v;
    for (int k = 0; k < 256; k++) rom[k] = to_f32(-(real'(k)) * PI / 256.0);

    tbl[0]  = '{0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000};
    tbl[1]  = '{1,    1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000};
    tbl[2]  = '{255,  1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000};
    tbl[3]  = '{256,  1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000};
    tbl[4]  = '{257,  1'b0, 1'b0, 1'b1, 1'b0, 32'hbc490fdb};
    tbl[5]  = '{384,  1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc90fdb};
    tbl[6]  = '{511,  1'b0, 1'b1, 1'b1, 1'b0, 32'hc04846cb};
    tbl[7]  = '{512,  1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000};
    tbl[8]  = '{768,  1'b0, 1'b0, 1'b1, 1'b0, 32'h80000000};
    tbl[9]  = '{769,  1'b0, 1'b0, 1'b1, 1'b0, 32'hbc490fdb};
    tbl[10] = '{1023, 1'b0, 1'b1, 1'b1, 1'b0, 32'hc04846cb};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 128'({o_valid, o_sof, o_eof, o_rot_en, o_sync_err, o_re, o_im, o_rom_addr}), 128'h0);
    rst = 1'b0;

    // Samples before any i_sof are dropped
    cap_n = 0;
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 1'b0);
      chk("idle_addr", 128'(o_rom_addr), 128'h0);
    end
    drain();
    chk("idle_no_valid", 128'(cap_n), 128'd0);

    // Two contiguous frames, i_sof only on the very first beat
    cap_n = 0;
    for (int b = 0; b < 1024; b++) beat(1'b1, b == 0);
    drain();
    chk("contig_count", 128'(cap_n), 128'd1024);
    for (int i = 0; i < 1024; i++) cref[i] = cap[i];
    for (int t = 0; t < 11; t++)
      chk($sformatf("tbl_beat%0d", tbl[t].beat),
          128'({cap[tbl[t].beat].sof, cap[tbl[t].beat].eof, cap[tbl[t].beat].rot,
                cap[tbl[t].beat].err, cap[tbl[t].beat].ang}),
          128'({tbl[t].sof, tbl[t].eof, tbl[t].rot, tbl[t].err, tbl[t].ang}));

    // One frame with random idle gaps must match the contiguous frame
    do_reset("gap_reset");
    cap_n = 0;
    sent = 0;
    while (sent < 512) begin
      v = 1'($urandom_range(0, 1));
      beat(v, v && (sent == 0));
      if (v) sent++;
    end
    drain();
    chk("gap_count", 128'(cap_n), 128'd512);
    errs = 0;
    for (int i = 0; i < 512; i++)
      if ({cap[i].sof, cap[i].eof, cap[i].rot, cap[i].err, cap[i].ang} !==
          {cref[i].sof, cref[i].eof, cref[i].rot, cref[i].err, cref[i].ang}) errs++;
    chk("gap_vs_contig", 128'(errs), 128'd0);

    // Resync: i_sof arrives at n = 300
    do_reset("resync_reset");
    cap_n = 0;
    for (int b = 0; b < 300; b++) beat(1'b1, b == 0);
    beat(1'b1, 1'b1);
    for (int b = 0; b < 300; b++) beat(1'b1, 1'b0);
    drain();
    errs = 0;
    for (int i = 0; i < cap_n; i++) if (cap[i].err) errs++;
    chk("resync_err_pulses", 128'(errs), 128'd1);
    chk("resync_beat", 128'({cap[300].sof, cap[300].rot, cap[300].err}), 128'(3'b101));
    chk("resync_pre", 128'({cap[299].rot, cap[299].err}), 128'(2'b10));
    chk("resync_half_lo", 128'({cap[555].rot, cap[555].ang}), 128'({1'b0, 32'h80000000}));
    chk("resync_half_hi", 128'({cap[556].rot, cap[557].ang}), 128'({1'b1, 32'hbc490fdb}));

    // Reset mid-frame at n = 400 with samples in flight
    do_reset("mid_pre_reset");
    for (int b = 0; b < 402; b++) beat(1'b1, b == 0);
    do_reset("mid_reset_outputs");
    cap_n = 0;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b0);
      chk("post_reset_addr", 128'(o_rom_addr), 128'h0);
    end
    beat(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    drain();
    chk("post_reset_count", 128'(cap_n), 128'd4);
    chk("post_reset_first", 128'({cap[0].sof, cap[0].rot, cap[0].err}), 128'(3'b100));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
